// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its iterative multiply/divide unit:
// operation codes, multiply/divide sequencer states and an op-class helper.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SLL   = 4'b0011,
        OP_SRL   = 4'b0100,
        OP_SRA   = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MULT  = 4'b1000,
        OP_MULTU = 4'b1001,
        OP_DIV   = 4'b1010,
        OP_DIVU  = 4'b1011,
        OP_NOR   = 4'b1100,
        OP_SLTU  = 4'b1101,
        OP_XOR   = 4'b1110
    } aluOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdState_t;

    // Multiply/divide codes are exactly the 10xx group.
    function automatic logic IS_MD_OP(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide unit: one bit per cycle for WIDTH cycles,
// shift-add multiply and restoring divide on operand magnitudes, with the
// sign applied when the result is written into HI/LO.
module md_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdState_t         state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] origA;
    logic             negA;
    logic             negQ;
    logic             divZero;

    logic             signedOp;
    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH-1:0] mulHiNext;
    logic [WIDTH-1:0] mulLoNext;
    logic [WIDTH:0]   divShift;
    logic [WIDTH:0]   divDiff;
    logic [WIDTH-1:0] divRemNext;
    logic [WIDTH-1:0] divQuoNext;
    logic [2*WIDTH-1:0] productSigned;
    logic [WIDTH-1:0] quoSigned;
    logic [WIDTH-1:0] remSigned;

    // Launch-time magnitudes plus the next multiply/divide step and the signed final results.
    always_comb begin
        signedOp      = (op == OP_MULT) || (op == OP_DIV);
        aNeg          = signedOp & a[WIDTH-1];
        bNeg          = signedOp & b[WIDTH-1];
        magA          = aNeg ? -a : a;
        magB          = bNeg ? -b : b;

        mulSum        = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
        mulHiNext     = mulSum[WIDTH:1];
        mulLoNext     = {mulSum[0], accLo[WIDTH-1:1]};

        divShift      = {accHi, accLo[WIDTH-1]};
        divDiff       = divShift - {1'b0, operand};
        divRemNext    = divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0];
        divQuoNext    = {accLo[WIDTH-2:0], ~divDiff[WIDTH]};

        productSigned = negQ ? -{mulHiNext, mulLoNext} : {mulHiNext, mulLoNext};
        quoSigned     = negQ ? -divQuoNext : divQuoNext;
        remSigned     = negA ? -divRemNext : divRemNext;
    end

    // Sequencer: launch from IDLE only, iterate WIDTH cycles, write HI/LO entering DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            accHi   <= '0;
            accLo   <= '0;
            operand <= '0;
            origA   <= '0;
            negA    <= 1'b0;
            negQ    <= 1'b0;
            divZero <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && IS_MD_OP(op)) begin
                        count   <= '0;
                        accHi   <= '0;
                        origA   <= a;
                        negA    <= aNeg;
                        negQ    <= aNeg ^ bNeg;
                        divZero <= (b == '0);
                        busy    <= 1'b1;
                        if (op[1]) begin
                            accLo   <= magA;
                            operand <= magB;
                            state   <= DIV;
                        end else begin
                            accLo   <= magB;
                            operand <= magA;
                            state   <= MUL;
                        end
                    end
                end
                MUL: begin
                    accHi <= mulHiNext;
                    accLo <= mulLoNext;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        hi    <= productSigned[2*WIDTH-1:WIDTH];
                        lo    <= productSigned[WIDTH-1:0];
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DIV: begin
                    accHi <= divRemNext;
                    accLo <= divQuoNext;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        if (divZero) begin
                            hi <= origA;
                            lo <= '1;
                        end else begin
                            hi <= remSigned;
                            lo <= quoSigned;
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_md.sv
// ALU top level: single-cycle combinational operations on resultALU, with
// multiply/divide handed to the iterative md_unit that owns HI/LO.
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               controlOpALU,
    input  logic [WIDTH-1:0]         numberAALU,
    input  logic [WIDTH-1:0]         numberBALU,
    input  logic [$clog2(WIDTH)-1:0] shamtALU,
    input  logic                     startALU,
    output logic [WIDTH-1:0]         resultALU,
    output logic                     isZeroResultALU,
    output logic                     busyALU,
    output logic                     doneALU,
    output logic [WIDTH-1:0]         hiALU,
    output logic [WIDTH-1:0]         loALU
);

    // Single-cycle result; multiply/divide and unused codes read as zero.
    always_comb begin
        resultALU = '0;
        case (controlOpALU)
            OP_AND:  resultALU = numberAALU & numberBALU;
            OP_OR:   resultALU = numberAALU | numberBALU;
            OP_ADD:  resultALU = numberAALU + numberBALU;
            OP_SUB:  resultALU = numberAALU - numberBALU;
            OP_SLT:  resultALU = {{(WIDTH-1){1'b0}}, $signed(numberAALU) < $signed(numberBALU)};
            OP_SLTU: resultALU = {{(WIDTH-1){1'b0}}, numberAALU < numberBALU};
            OP_NOR:  resultALU = ~(numberAALU | numberBALU);
            OP_XOR:  resultALU = numberAALU ^ numberBALU;
            OP_SLL:  resultALU = numberBALU << shamtALU;
            OP_SRL:  resultALU = numberBALU >> shamtALU;
            OP_SRA:  resultALU = $signed(numberBALU) >>> shamtALU;
            default: resultALU = '0;
        endcase
    end

    assign isZeroResultALU = (resultALU == '0);

    md_unit #(
        .WIDTH (WIDTH)
    ) mdUnit (
        .clk   (clk),
        .reset (reset),
        .op    (controlOpALU),
        .a     (numberAALU),
        .b     (numberBALU),
        .start (startALU),
        .busy  (busyALU),
        .done  (doneALU),
        .hi    (hiALU),
        .lo    (loALU)
    );

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: combinational ops checked immediately against
// a reference model, multiply/divide results queued at launch and checked by a
// monitor whenever doneALU pulses.
module tb_alu_md;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        controlOpALU;
    logic [WIDTH-1:0]  numberAALU;
    logic [WIDTH-1:0]  numberBALU;
    logic [4:0]        shamtALU;
    logic              startALU;
    logic [WIDTH-1:0]  resultALU;
    logic              isZeroResultALU;
    logic              busyALU;
    logic              doneALU;
    logic [WIDTH-1:0]  hiALU;
    logic [WIDTH-1:0]  loALU;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          launch;
    } expMd_t;

    expMd_t sb[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;

    alu_md #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .controlOpALU    (controlOpALU),
        .numberAALU      (numberAALU),
        .numberBALU      (numberBALU),
        .shamtALU        (shamtALU),
        .startALU        (startALU),
        .resultALU       (resultALU),
        .isZeroResultALU (isZeroResultALU),
        .busyALU         (busyALU),
        .doneALU         (doneALU),
        .hiALU           (hiALU),
        .loALU           (loALU)
    );

    // Free-running clock and edge counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] aluRef(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        longint sa = longint'($signed(a));
        longint sb2 = longint'($signed(b));
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return (sa < sb2) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            4'b1110: return a ^ b;
            4'b1101: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            4'b0011: return b << sh;
            4'b0100: return b >> sh;
            4'b0101: return 32'(sb2 >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic void mdRef(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] h,
                                  output logic [31:0] l);
        longint sa = longint'($signed(a));
        longint sbv = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        logic [63:0] p;
        case (op)
            4'b1000: begin p = 64'(sa * sbv); h = p[63:32]; l = p[31:0]; end
            4'b1001: begin p = 64'(ua * ub);  h = p[63:32]; l = p[31:0]; end
            4'b1010: begin
                if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin h = 32'(sa % sbv); l = 32'(sa / sbv); end
            end
            default: begin
                if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin h = 32'(ua % ub); l = 32'(ua / ub); end
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive a single-cycle op mid-cycle and compare result and zero flag.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] exp;
        @(negedge clk); #1;
        controlOpALU = op;
        numberAALU   = a;
        numberBALU   = b;
        shamtALU     = sh;
        #1;
        exp = aluRef(op, a, b, sh);
        checkOutput($sformatf("result_op%0h", op), 64'(resultALU), 64'(exp));
        checkOutput($sformatf("zero_op%0h", op), 64'(isZeroResultALU), 64'(exp == 32'd0));
    endtask

    // Pulse startALU for one cycle; queue the expected HI/LO when it should be accepted.
    task automatic launchMd(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input bit expectAccept);
        expMd_t e;
        @(negedge clk); #1;
        controlOpALU = op;
        numberAALU   = a;
        numberBALU   = b;
        startALU     = 1'b1;
        if (expectAccept) begin
            mdRef(op, a, b, e.hi, e.lo);
            e.launch = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk); #1;
        startALU   = 1'b0;
        numberAALU = $urandom;
        numberBALU = $urandom;
        if (expectAccept)
            checkOutput("busy_after_launch", 64'(busyALU), 64'd1);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic idleCheck(input int n);
        repeat (n) @(negedge clk);
        #1;
        checkOutput("busy_idle", 64'(busyALU), 64'd0);
    endtask

    // Monitor: every doneALU pulse must match the oldest queued op, on time.
    task automatic monitor();
        expMd_t e;
        forever begin
            @(negedge clk);
            if (doneALU === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("md_hi", 64'(hiALU), 64'(e.hi));
                    checkOutput("md_lo", 64'(loALU), 64'(e.lo));
                    checkOutput("md_latency", 64'(cyc), 64'(e.launch + WIDTH));
                    checkOutput("busy_in_done", 64'(busyALU), 64'd1);
                end
            end
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;

        reset        = 1'b1;
        controlOpALU = 4'b0000;
        numberAALU   = '0;
        numberBALU   = '0;
        shamtALU     = '0;
        startALU     = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_busy", 64'(busyALU), 64'd0);
        checkOutput("rst_done", 64'(doneALU), 64'd0);
        checkOutput("rst_hi", 64'(hiALU), 64'd0);
        checkOutput("rst_lo", 64'(loALU), 64'd0);
        reset = 1'b0;

        applyStimulus(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0);
        checkOutput("add_wrap", 64'(resultALU), 64'h8000_0000);
        applyStimulus(4'b0110, 32'd5, 32'd5, 5'd0);
        checkOutput("sub_zero_flag", 64'(isZeroResultALU), 64'd1);
        applyStimulus(4'b0101, 32'h1234_5678, 32'h8000_0000, 5'd4);
        checkOutput("sra_dir", 64'(resultALU), 64'hF800_0000);
        applyStimulus(4'b0100, 32'h1234_5678, 32'h8000_0000, 5'd4);
        checkOutput("srl_dir", 64'(resultALU), 64'h0800_0000);
        applyStimulus(4'b1101, 32'd1, 32'hFFFF_FFFF, 5'd0);
        checkOutput("sltu_dir", 64'(resultALU), 64'd1);
        applyStimulus(4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd0);
        checkOutput("slt_dir", 64'(resultALU), 64'd0);

        for (int i = 0; i < 48; i++) begin
            a = (i % 7 == 0) ? 32'd0 : $urandom;
            b = (i % 5 == 0) ? a : $urandom;
            applyStimulus(4'($urandom_range(0, 15)), a, b, 5'($urandom));
        end

        launchMd(4'b1000, 32'hFFFF_FFFE, 32'd3, 1'b1);
        waitDrain(WIDTH + 20);
        launchMd(4'b1001, 32'hFFFF_FFFE, 32'd3, 1'b1);
        waitDrain(WIDTH + 20);
        launchMd(4'b1010, 32'hFFFF_FFF9, 32'd2, 1'b1);
        waitDrain(WIDTH + 20);
        launchMd(4'b1011, 32'd7, 32'd0, 1'b1);
        waitDrain(WIDTH + 20);
        launchMd(4'b1010, 32'hFFFF_FFF9, 32'd0, 1'b1);
        waitDrain(WIDTH + 20);

        launchMd(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        repeat (4) @(negedge clk);
        launchMd(4'b1001, 32'd3, 32'd3, 1'b0);
        waitDrain(WIDTH + 20);
        idleCheck(WIDTH + 8);

        for (int i = 0; i < 14; i++) begin
            op = 4'($urandom_range(8, 11));
            a  = $urandom;
            b  = (i % 4 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            launchMd(op, a, b, 1'b1);
            waitDrain(WIDTH + 20);
        end

        launchMd(4'b1001, 32'd6, 32'd7, 1'b1);
        n = 0;
        while (doneALU !== 1'b1 && n < WIDTH + 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (doneALU !== 1'b1)
            checkOutput("done_wait_timeout", 64'(doneALU), 64'd1);
        controlOpALU = 4'b1000;
        startALU     = 1'b1;
        @(negedge clk); #1;
        startALU = 1'b0;
        idleCheck(WIDTH + 8);
        waitDrain(4);

        launchMd(4'b1001, 32'd10, 32'd10, 1'b0);
        repeat (13) @(negedge clk);
        #1;
        reset        = 1'b1;
        startALU     = 1'b1;
        controlOpALU = 4'b0010;
        numberAALU   = 32'd3;
        numberBALU   = 32'd4;
        #1;
        checkOutput("result_during_reset", 64'(resultALU), 64'd7);
        @(negedge clk); #1;
        reset    = 1'b0;
        startALU = 1'b0;
        checkOutput("abort_busy", 64'(busyALU), 64'd0);
        checkOutput("abort_done", 64'(doneALU), 64'd0);
        checkOutput("abort_hi", 64'(hiALU), 64'd0);
        checkOutput("abort_lo", 64'(loALU), 64'd0);
        idleCheck(WIDTH + 8);
        checkOutput("abort_hi_late", 64'(hiALU), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
